hist2d_accum: RTL and testbench

HIST2D_ACCUM -- requirements
Module: hist2d_accum

---
 rtl/hist2d_pkg.sv | 16 +
 rtl/hist_ram.sv | 29 ++
 rtl/hist2d_accum.sv | 207 ++++++++++++++++++++
 tb/tb_hist2d_accum.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hist2d_pkg.sv
// Shared definitions for the 2-D histogram accumulator and its readout users.
package hist2d_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_STREAM = 2'd3
    } hist_state_t;

    // Number of bins for a square histogram with bin_bits per axis.
    function automatic int unsigned hist_depth(input int unsigned bin_bits);
        return 32'd1 << (2 * bin_bits);
    endfunction

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port count memory: one write port, one read port, registered read.
// A read and a write to the same address on one edge return the old contents.
module hist_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port, one cycle latency
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/hist2d_accum.sv
// 2-D histogram accumulator: counts strobes per {q,i} bin, clears and streams bins.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_CLEAR  | sweep zero into every bin, one per cycle, then accumulate
//   ST_ACCUM  | accept strobes through the 2-stage read-modify-write
//   ST_DRAIN  | wait for the last increment to land before reading out
//   ST_STREAM | present every bin in address order with valid/ready
module hist2d_accum
    import hist2d_pkg::*;
#(
    parameter int BIN_BITS      = 6,
    parameter int COUNT_W       = 16,
    parameter bit CLEAR_ON_READ = 1'b0
) (
    input  logic                clk100,
    input  logic                rst_n,
    input  logic                data_in,
    input  logic [BIN_BITS-1:0] i_bin,
    input  logic [BIN_BITS-1:0] q_bin,
    input  logic                clear_start,
    input  logic                stream_start,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [BIN_BITS-1:0] out_i,
    output logic [BIN_BITS-1:0] out_q,
    output logic [COUNT_W-1:0]  out_count,
    output logic                out_last,
    output logic                busy,
    output logic                dropped,
    output logic                saturated
);

    localparam int                ADDR_W    = 2 * BIN_BITS;
    localparam int                DEPTH     = int'(hist_depth(BIN_BITS));
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    hist_state_t        state;
    logic [ADDR_W-1:0]  sweep_addr;
    logic [ADDR_W-1:0]  out_addr;
    logic [ADDR_W-1:0]  strobe_addr;

    logic               s1_valid;
    logic [ADDR_W-1:0]  s1_addr;
    logic               wb_valid;
    logic [ADDR_W-1:0]  wb_addr;
    logic [COUNT_W-1:0] wb_data;

    logic [ADDR_W-1:0]  rd_addr;
    logic [COUNT_W-1:0] rd_data;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COUNT_W-1:0] wr_data;

    logic               fwd_hit;
    logic [COUNT_W-1:0] cur_count;
    logic               at_max;
    logic               xfer;

    assign strobe_addr = {q_bin, i_bin};

    // The RAM read misses the write made on the same edge; the previous write
    // is kept in wb_* and substituted when it targets the bin being incremented.
    assign fwd_hit   = wb_valid && (wb_addr == s1_addr);
    assign cur_count = fwd_hit ? wb_data : rd_data;
    assign at_max    = &cur_count;

    assign xfer      = (state == ST_STREAM) && out_valid && out_ready;
    assign busy      = (state == ST_CLEAR) || (state == ST_STREAM);
    assign dropped   = rst_n && data_in && (state != ST_ACCUM);
    assign out_i     = out_addr[BIN_BITS-1:0];
    assign out_q     = out_addr[ADDR_W-1:BIN_BITS];

    // Read address: strobe address while accumulating; during the stream the
    // RAM always holds the bin after the one on the outputs.
    always_comb begin
        rd_addr = strobe_addr;
        case (state)
            ST_CLEAR:  rd_addr = strobe_addr;
            ST_ACCUM:  rd_addr = strobe_addr;
            ST_DRAIN:  rd_addr = '0;
            ST_STREAM: begin
                if (!out_valid) begin
                    rd_addr = ADDR_W'(1);
                end else if (xfer) begin
                    rd_addr = out_addr + ADDR_W'(2);
                end else begin
                    rd_addr = out_addr + ADDR_W'(1);
                end
            end
        endcase
    end

    // Write port arbitration: sweep, increment, or clear-on-read
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s1_addr;
        wr_data = at_max ? cur_count : cur_count + COUNT_W'(1);
        case (state)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = sweep_addr;
                wr_data = '0;
            end
            ST_ACCUM, ST_DRAIN: begin
                wr_en = s1_valid;
            end
            ST_STREAM: begin
                wr_en   = CLEAR_ON_READ && xfer;
                wr_addr = out_addr;
                wr_data = '0;
            end
        endcase
    end

    hist_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (COUNT_W)
    ) u_ram (
        .clk     (clk100),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // RMW pipeline: stage-1 tracking and a copy of the last RAM write for forwarding.
    // A strobe coinciding with clear_start is not carried into the sweep.
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            s1_valid <= (state == ST_ACCUM) && data_in && !clear_start;
            s1_addr  <= strobe_addr;
            wb_valid <= wr_en;
            wb_addr  <= wr_addr;
            wb_data  <= wr_data;
        end
    end

    // Sequencing FSM with registered stream outputs and sticky saturation flag
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            sweep_addr <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_addr   <= '0;
            out_count  <= '0;
            saturated  <= 1'b0;
        end else begin
            if (s1_valid && at_max) begin
                saturated <= 1'b1;
            end
            case (state)
                ST_CLEAR: begin
                    sweep_addr <= sweep_addr + ADDR_W'(1);
                    if (sweep_addr == LAST_ADDR) begin
                        sweep_addr <= '0;
                        state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (clear_start) begin
                        state <= ST_CLEAR;
                    end else if (stream_start) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (clear_start) begin
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        sweep_addr <= '0;
                        state      <= ST_CLEAR;
                    end else if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_addr  <= '0;
                        out_count <= rd_data;
                        out_last  <= 1'b0;
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= ST_ACCUM;
                        end else begin
                            out_addr  <= out_addr + ADDR_W'(1);
                            out_count <= rd_data;
                            out_last  <= ((out_addr + ADDR_W'(1)) == LAST_ADDR);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hist2d_accum.sv
// Directed bench for hist2d_accum: two instances (plain and clear-on-read) share stimulus.
module tb_hist2d_accum;

    localparam int BB = 2;
    localparam int CW = 4;

    logic          clk100 = 1'b0;
    logic          rst_n;
    logic          data_in;
    logic [BB-1:0] i_bin;
    logic [BB-1:0] q_bin;
    logic          clear_start;
    logic          stream_start;
    logic          out_ready;

    logic          ov0, ol0, busy0, dr0, sat0;
    logic [BB-1:0] oi0, oq0;
    logic [CW-1:0] oc0;
    logic          ov1, ol1, busy1, dr1, sat1;
    logic [BB-1:0] oi1, oq1;
    logic [CW-1:0] oc1;

    int n_chk = 0;
    int n_bad = 0;
    int exp0 [16];
    int exp1 [16];
    int n_cyc;

    always #5 clk100 = ~clk100;

    hist2d_accum #(.BIN_BITS(BB), .COUNT_W(CW), .CLEAR_ON_READ(1'b0)) u0 (
        .clk100(clk100), .rst_n(rst_n), .data_in(data_in), .i_bin(i_bin), .q_bin(q_bin),
        .clear_start(clear_start), .stream_start(stream_start), .out_ready(out_ready),
        .out_valid(ov0), .out_i(oi0), .out_q(oq0), .out_count(oc0), .out_last(ol0),
        .busy(busy0), .dropped(dr0), .saturated(sat0)
    );

    hist2d_accum #(.BIN_BITS(BB), .COUNT_W(CW), .CLEAR_ON_READ(1'b1)) u1 (
        .clk100(clk100), .rst_n(rst_n), .data_in(data_in), .i_bin(i_bin), .q_bin(q_bin),
        .clear_start(clear_start), .stream_start(stream_start), .out_ready(out_ready),
        .out_valid(ov1), .out_i(oi1), .out_q(oq1), .out_count(oc1), .out_last(ol1),
        .busy(busy1), .dropped(dr1), .saturated(sat1)
    );

    task automatic check_val(input string tag, input int got, input int expv);
        n_chk++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic strobe(input int i, input int q, input int n);
        for (int k = 0; k < n; k++) begin
            data_in = 1'b1;
            i_bin   = BB'(i);
            q_bin   = BB'(q);
            tick();
        end
        data_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
        end
    endtask

    task automatic exp_zero();
        for (int k = 0; k < 16; k++) begin
            exp0[k] = 0;
            exp1[k] = 0;
        end
    endtask

    // Request a stream and check every word; optional abort, drop probe and
    // a strobe coinciding with stream_start (start_addr >= 0).
    task automatic run_stream(input bit rand_rdy, input int abort_idx,
                              input int drop_idx, input int start_addr);
        int  got     = 0;
        bit  done    = 1'b0;
        bit  aborted = 1'b0;
        bit  stalled = 1'b0;
        int  held    = 0;
        int  drop_ph = 0;
        int  n;
        stream_start = 1'b1;
        if (start_addr >= 0) begin
            data_in = 1'b1;
            i_bin   = BB'(start_addr % 4);
            q_bin   = BB'(start_addr / 4);
        end
        tick();
        stream_start = 1'b0;
        data_in      = 1'b0;
        for (int cyc = 0; cyc < 300 && !done && !aborted; cyc++) begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drop_ph == 1) begin
                data_in = 1'b0;
                drop_ph = 2;
            end else if (drop_idx >= 0 && drop_ph == 0 && ov0 && got == drop_idx) begin
                data_in = 1'b1;
                i_bin   = BB'(1);
                q_bin   = BB'(2);
                drop_ph = 1;
            end
            if (abort_idx >= 0 && ov0 && got == abort_idx) begin
                clear_start = 1'b1;
                aborted     = 1'b1;
            end
            @(negedge clk100);
            if (stalled) begin
                check_val("stall_hold", int'({ov0, oi0, oq0, oc0, ol0}), held);
            end
            if (drop_ph == 1) begin
                check_val("drop_pulse0", int'(dr0), 1);
                check_val("drop_pulse1", int'(dr1), 1);
            end else if (drop_ph == 2) begin
                check_val("drop_once", int'(dr0), 0);
                drop_ph = 3;
            end
            if (!aborted && ov0 && out_ready) begin
                if (got < 16) begin
                    check_val("strm_i", int'(oi0), got % 4);
                    check_val("strm_q", int'(oq0), got / 4);
                    check_val("strm_cnt0", int'(oc0), exp0[got]);
                    check_val("strm_cnt1", int'(oc1), exp1[got]);
                    check_val("strm_last", int'(ol0), (got == 15) ? 1 : 0);
                end else begin
                    check_val("strm_extra", got, 15);
                end
                got++;
                if (ol0) done = 1'b1;
            end
            stalled = ov0 && !out_ready && !aborted;
            held    = int'({ov0, oi0, oq0, oc0, ol0});
            tick();
        end
        out_ready = 1'b1;
        data_in   = 1'b0;
        if (aborted) begin
            clear_start = 1'b0;
            @(negedge clk100);
            check_val("abort_valid", int'(ov0), 0);
            check_val("abort_busy", int'(busy0), 1);
            n = 0;
            do begin
                @(posedge clk100);
                @(negedge clk100);
                n++;
            end while (busy0 && n < 40);
            check_val("abort_clr_len", n, 16);
            tick();
        end else begin
            check_val("xfers", got, 16);
            @(negedge clk100);
            check_val("end_valid", int'(ov0), 0);
            check_val("end_busy", int'(busy0), 0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        data_in      = 1'b1;
        i_bin        = '0;
        q_bin        = '0;
        clear_start  = 1'b0;
        stream_start = 1'b0;
        out_ready    = 1'b1;
        tick();
        tick();
        @(negedge clk100);
        check_val("rst_busy", int'(busy0), 1);
        check_val("rst_valid", int'(ov0), 0);
        check_val("rst_last", int'(ol0), 0);
        check_val("rst_data", int'({oi0, oq0, oc0}), 0);
        check_val("rst_dropped", int'(dr0), 0);
        check_val("rst_sat", int'(sat0), 0);
        check_val("rst_busy1", int'(busy1), 1);
        tick();
        rst_n   = 1'b1;
        data_in = 1'b0;

        n_cyc = 0;
        do begin
            @(posedge clk100);
            @(negedge clk100);
            n_cyc++;
        end while (busy0 && n_cyc < 40);
        check_val("clr_len", n_cyc, 16);
        tick();
        idle(2);

        // Empty histogram
        exp_zero();
        run_stream(1'b0, -1, -1, -1);

        // Five back-to-back hits on (1,2) then one on (0,0)
        strobe(1, 2, 5);
        strobe(0, 0, 1);
        idle(3);
        exp0[9] = 5; exp0[0] = 1;
        exp1[9] = 5; exp1[0] = 1;
        run_stream(1'b0, -1, -1, -1);

        // Clear-on-read instance now empty; random backpressure and a dropped strobe
        for (int k = 0; k < 16; k++) exp1[k] = 0;
        run_stream(1'b1, -1, 3, -1);
        run_stream(1'b0, -1, -1, -1);

        // Saturation boundary on (3,3)
        strobe(3, 3, 15);
        idle(3);
        @(negedge clk100);
        check_val("sat_at15_0", int'(sat0), 0);
        check_val("sat_at15_1", int'(sat1), 0);
        tick();
        strobe(3, 3, 5);
        idle(3);
        @(negedge clk100);
        check_val("sat_set0", int'(sat0), 1);
        check_val("sat_set1", int'(sat1), 1);
        tick();

        // Strobe to (2,1) in the same cycle as stream_start is counted
        exp0[15] = 15; exp0[6] = 1;
        exp1[15] = 15; exp1[6] = 1;
        run_stream(1'b0, -1, -1, 6);

        // Abort at the 7th word, then everything must be zero
        for (int k = 0; k < 16; k++) exp1[k] = 0;
        run_stream(1'b0, 6, -1, -1);
        exp_zero();
        run_stream(1'b1, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
